coeff_dpram_ctrl: RTL and testbench

COEFF_DPRAM_CTRL -- requirements
Module: coeff_dpram_ctrl

---
 rtl/coeff_dpram_ctrl_pkg.sv | 16 +
 rtl/coeff_dpram_ctrl_if.sv | 33 +++
 rtl/coeff_dpram_core.sv | 45 ++++
 rtl/coeff_dpram_ctrl.sv | 138 +++++++++++++
 tb/tb_coeff_dpram_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/coeff_dpram_ctrl_pkg.sv
// Shared definitions for the coefficient dual-port RAM controller:
// default geometry, same-port write behaviour encodings and FSM states.
package coeff_dpram_ctrl_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_ADDR_W = 8;

    localparam int WR_FIRST = 0;
    localparam int RD_FIRST = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/coeff_dpram_ctrl_if.sv
// Two-port access bundle for the coefficient RAM: requests in, read data and valids out.
interface coeff_dpram_ctrl_if
    import coeff_dpram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              en_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] q_a;
    logic              vld_a;

    logic              en_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] q_b;
    logic              vld_b;

    modport master (
        output en_a, we_a, addr_a, data_a, en_b, we_b, addr_b, data_b,
        input  q_a, vld_a, q_b, vld_b
    );

    modport slave (
        input  en_a, we_a, addr_a, data_a, en_b, we_b, addr_b, data_b,
        output q_a, vld_a, q_b, vld_b
    );

endinterface

// File: rtl/coeff_dpram_core.sv
// True dual-port array with registered read ports; the array itself has no reset.
module coeff_dpram_core
    import coeff_dpram_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WR_MODE = WR_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A is written last so it wins when both ports hit the same word.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        if (we_a) mem[addr_a] <= din_a;
    end

    // en_x only gates the output register, so the clear can write through
    // port A without disturbing the held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (en_a) dout_a <= (we_a && WR_MODE == WR_FIRST) ? din_a : mem[addr_a];
            if (en_b) dout_b <= (we_b && WR_MODE == WR_FIRST) ? din_b : mem[addr_b];
        end
    end

endmodule

// File: rtl/coeff_dpram_ctrl.sv
// Coefficient RAM controller: zero-fill sequencer, port muxing, collision detect, read pipeline.
//   state    | meaning
//   ST_IDLE  | user ports own the array
//   ST_CLEAR | one zero word per cycle through port A, user accesses dropped
module coeff_dpram_ctrl
    import coeff_dpram_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = WR_FIRST,
    parameter int CLR_ON_RST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    output logic               busy,
    output logic               collision,
    coeff_dpram_ctrl_if.slave  bus
);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              auto_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            auto_clr <= (CLR_ON_RST != 0);
        end else begin
            auto_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_req || auto_clr) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_req) begin
                        clr_cnt <= '0;
                    end else if (&clr_cnt) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

    logic              acc_a, acc_b, wr_a, wr_b, coll_now;
    logic              core_we_a;
    logic [ADDR_W-1:0] core_addr_a;
    logic [DATA_W-1:0] core_din_a, dout_a, dout_b;

    assign acc_a    = !busy && bus.en_a;
    assign acc_b    = !busy && bus.en_b;
    assign wr_a     = acc_a && bus.we_a;
    assign wr_b     = acc_b && bus.we_b;
    assign coll_now = wr_a && wr_b && (bus.addr_a == bus.addr_b);

    assign core_we_a   = busy || wr_a;
    assign core_addr_a = busy ? clr_cnt : bus.addr_a;
    assign core_din_a  = busy ? '0 : bus.data_a;

    coeff_dpram_core #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .WR_MODE (WR_MODE)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en_a   (acc_a),
        .we_a   (core_we_a),
        .addr_a (core_addr_a),
        .din_a  (core_din_a),
        .dout_a (dout_a),
        .en_b   (acc_b),
        .we_b   (wr_b),
        .addr_b (bus.addr_b),
        .din_b  (bus.data_b),
        .dout_b (dout_b)
    );

    logic vld1_a, vld1_b, coll1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_a <= 1'b0;
            vld1_b <= 1'b0;
            coll1  <= 1'b0;
        end else begin
            vld1_a <= acc_a;
            vld1_b <= acc_b;
            coll1  <= coll_now;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              vld2_a, vld2_b, coll2;
        logic [DATA_W-1:0] q2_a, q2_b;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld2_a <= 1'b0;
                vld2_b <= 1'b0;
                coll2  <= 1'b0;
                q2_a   <= '0;
                q2_b   <= '0;
            end else begin
                vld2_a <= vld1_a;
                vld2_b <= vld1_b;
                coll2  <= coll1;
                if (vld1_a) q2_a <= dout_a;
                if (vld1_b) q2_b <= dout_b;
            end
        end

        assign bus.q_a   = q2_a;
        assign bus.q_b   = q2_b;
        assign bus.vld_a = vld2_a;
        assign bus.vld_b = vld2_b;
        assign collision = coll2;
    end else begin : g_lat1
        assign bus.q_a   = dout_a;
        assign bus.q_b   = dout_b;
        assign bus.vld_a = vld1_a;
        assign bus.vld_b = vld1_b;
        assign collision = coll1;
    end

endmodule

// File: tb/tb_coeff_dpram_ctrl.sv
// Directed bench: two instances (RD_LAT=1/write-first and RD_LAT=2/read-first) driven in lockstep.
module tb_coeff_dpram_ctrl;
    import coeff_dpram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_req = 1'b0;
    logic busy0, busy1, coll0, coll1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    coeff_dpram_ctrl_if #(.DATA_W(12), .ADDR_W(8)) bus0 ();
    coeff_dpram_ctrl_if #(.DATA_W(12), .ADDR_W(8)) bus1 ();

    coeff_dpram_ctrl #(
        .DATA_W(12), .ADDR_W(8), .RD_LAT(1), .WR_MODE(WR_FIRST), .CLR_ON_RST(1)
    ) u0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0), .collision(coll0), .bus(bus0)
    );

    coeff_dpram_ctrl #(
        .DATA_W(12), .ADDR_W(8), .RD_LAT(2), .WR_MODE(RD_FIRST), .CLR_ON_RST(1)
    ) u1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .collision(coll1), .bus(bus1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drv();
        bus0.en_a = 1'b0; bus0.we_a = 1'b0; bus0.en_b = 1'b0; bus0.we_b = 1'b0;
        bus1.en_a = 1'b0; bus1.we_a = 1'b0; bus1.en_b = 1'b0; bus1.we_b = 1'b0;
    endtask

    task automatic drv_a(input logic we, input logic [7:0] addr, input logic [11:0] data);
        bus0.en_a = 1'b1; bus0.we_a = we; bus0.addr_a = addr; bus0.data_a = data;
        bus1.en_a = 1'b1; bus1.we_a = we; bus1.addr_a = addr; bus1.data_a = data;
    endtask

    task automatic drv_b(input logic we, input logic [7:0] addr, input logic [11:0] data);
        bus0.en_b = 1'b1; bus0.we_b = we; bus0.addr_b = addr; bus0.data_b = data;
        bus1.en_b = 1'b1; bus1.we_b = we; bus1.addr_b = addr; bus1.data_b = data;
    endtask

    // Issue whatever is driven for one cycle, then follow it through both latencies.
    // a0/b0: expected q on the 1-cycle instance, a1/b1: on the 2-cycle instance.
    task automatic step_check(input string tag, input logic ca, input logic cb,
                              input logic [11:0] a0, input logic [11:0] a1,
                              input logic [11:0] b0, input logic [11:0] b1,
                              input logic coll);
        tick();
        idle_drv();
        chk({tag, " u0 vld_a"}, bus0.vld_a, ca);
        chk({tag, " u0 vld_b"}, bus0.vld_b, cb);
        chk({tag, " u0 coll"}, coll0, coll);
        if (ca) chk({tag, " u0 q_a"}, bus0.q_a, a0);
        if (cb) chk({tag, " u0 q_b"}, bus0.q_b, b0);
        chk({tag, " u1 vld_a early"}, bus1.vld_a, 1'b0);
        chk({tag, " u1 vld_b early"}, bus1.vld_b, 1'b0);
        chk({tag, " u1 coll early"}, coll1, 1'b0);
        tick();
        chk({tag, " u0 vld_a late"}, bus0.vld_a, 1'b0);
        chk({tag, " u0 vld_b late"}, bus0.vld_b, 1'b0);
        chk({tag, " u0 coll late"}, coll0, 1'b0);
        if (ca) chk({tag, " u0 q_a hold"}, bus0.q_a, a0);
        chk({tag, " u1 vld_a"}, bus1.vld_a, ca);
        chk({tag, " u1 vld_b"}, bus1.vld_b, cb);
        chk({tag, " u1 coll"}, coll1, coll);
        if (ca) chk({tag, " u1 q_a"}, bus1.q_a, a1);
        if (cb) chk({tag, " u1 q_b"}, bus1.q_b, b1);
    endtask

    // Measure busy length while hammering both ports; nothing may leak through.
    task automatic run_clear(input string tag);
        int  n0 = 0;
        int  n1 = 0;
        int  spur = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (busy0) n0++;
            if (busy1) n1++;
            if (seen && (bus0.vld_a || bus0.vld_b || coll0 || bus1.vld_a || bus1.vld_b || coll1))
                spur++;
            if (busy0 || busy1) begin
                seen = 1'b1;
                drv_a(1'b1, 8'd17, 12'hFFF);
                drv_b(1'b1, 8'd17, 12'hEEE);
            end else if (seen) begin
                break;
            end
        end
        idle_drv();
        chk({tag, " u0 busy cycles"}, n0, 256);
        chk({tag, " u1 busy cycles"}, n1, 256);
        chk({tag, " outputs while busy"}, spur, 0);
    endtask

    initial begin
        bus0.addr_a = '0; bus0.data_a = '0; bus0.addr_b = '0; bus0.data_b = '0;
        bus1.addr_a = '0; bus1.data_a = '0; bus1.addr_b = '0; bus1.data_b = '0;
        idle_drv();

        repeat (3) tick();
        chk("rst u0 q_a", bus0.q_a, 12'h0);
        chk("rst u0 q_b", bus0.q_b, 12'h0);
        chk("rst u1 q_a", bus1.q_a, 12'h0);
        chk("rst u1 q_b", bus1.q_b, 12'h0);
        chk("rst vld", {bus0.vld_a, bus0.vld_b, bus1.vld_a, bus1.vld_b}, 4'h0);
        chk("rst busy/coll", {busy0, busy1, coll0, coll1}, 4'h0);

        rst = 1'b0;
        run_clear("autoclr");

        drv_a(1'b0, 8'd0, 12'h0);
        step_check("rd0", 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drv_a(1'b0, 8'd17, 12'h0);
        step_check("rd17", 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drv_a(1'b0, 8'd255, 12'h0);
        step_check("rd255", 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);

        drv_a(1'b1, 8'd5, 12'h0AB);
        step_check("wr5", 1'b1, 1'b0, 12'h0AB, 12'h000, 12'h0, 12'h0, 1'b0);
        drv_b(1'b0, 8'd5, 12'h0);
        step_check("lat rd5", 1'b0, 1'b1, 12'h0, 12'h0, 12'h0AB, 12'h0AB, 1'b0);

        drv_a(1'b1, 8'd9, 12'h111);
        step_check("wr9 first", 1'b1, 1'b0, 12'h111, 12'h000, 12'h0, 12'h0, 1'b0);
        drv_a(1'b1, 8'd9, 12'h222);
        step_check("wrmode", 1'b1, 1'b0, 12'h222, 12'h111, 12'h0, 12'h0, 1'b0);
        drv_a(1'b0, 8'd9, 12'h0);
        step_check("rd9", 1'b1, 1'b0, 12'h222, 12'h222, 12'h0, 12'h0, 1'b0);

        drv_a(1'b1, 8'd9, 12'h333);
        drv_b(1'b0, 8'd9, 12'h0);
        step_check("xport", 1'b1, 1'b1, 12'h333, 12'h222, 12'h222, 12'h222, 1'b0);

        drv_a(1'b1, 8'd40, 12'h123);
        drv_b(1'b1, 8'd40, 12'h456);
        step_check("coll40", 1'b1, 1'b1, 12'h123, 12'h000, 12'h456, 12'h000, 1'b1);
        drv_b(1'b0, 8'd40, 12'h0);
        step_check("rd40", 1'b0, 1'b1, 12'h0, 12'h0, 12'h123, 12'h123, 1'b0);

        drv_a(1'b1, 8'd41, 12'hA41);
        drv_b(1'b1, 8'd42, 12'hB42);
        step_check("nocoll", 1'b1, 1'b1, 12'hA41, 12'h000, 12'hB42, 12'h000, 1'b0);

        step_check("idle", 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);

        drv_a(1'b1, 8'd200, 12'h7E7);
        step_check("wr200", 1'b1, 1'b0, 12'h7E7, 12'h000, 12'h0, 12'h0, 1'b0);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (99) tick();
        chk("midclr busy", {busy0, busy1}, 2'b11);
        rst = 1'b1;
        drv_a(1'b0, 8'd5, 12'h0);
        tick();
        chk("rstclr busy", {busy0, busy1}, 2'b00);
        chk("rstclr vld", {bus0.vld_a, bus1.vld_a}, 2'b00);
        tick();
        chk("rstclr vld2", {bus0.vld_a, bus1.vld_a}, 2'b00);
        idle_drv();
        rst = 1'b0;
        run_clear("reclr");

        drv_a(1'b0, 8'd200, 12'h0);
        step_check("rd200", 1'b1, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        drv_b(1'b0, 8'd40, 12'h0);
        step_check("rd40 clr", 1'b0, 1'b1, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
